instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: stall  input  1  hold PC and IF/ID register.
REQ-004 SHALL have port: flush  input  1  squash IF/ID contents to NOP.
REQ-005 SHALL have port: halt  input  1  enter HALT state.
REQ-006 SHALL have port: branch_taken  input  1  redirect PC.
REQ-007 SHALL have port: branch_target  input  8  redirect address.
REQ-008 SHALL have port: imem_address  output  8  instruction memory address; combinational copy of PC.
REQ-009 SHALL have port: imem_data  input  16  instruction word from instruction memory; combinational w.r.t. imem_address.
REQ-010 SHALL have port: if_instruction  output  16  registered IF/ID instruction.
REQ-011 SHALL have port: if_pc_plus1  output  8  registered PC+1 of if_instruction.
REQ-012 SHALL have port: if_valid  output  1  if_instruction is a real fetch.
REQ-013 SHALL have port: halted  output  1  high while in HALT state.
REQ-014 SHALL have port: fetch_count  output  16  valid-fetch counter (see Configuration).

Function
REQ-015 SHALL implement states START, RUN, HALT; START lasts exactly one cycle after reset release, then RUN.
REQ-016 In START, SHALL present PC=0x00, hold PC, load IF/ID with NOP (16'h0000), if_valid=0.
REQ-017 In RUN, per-cycle priority SHALL be: halt > branch_taken > flush > stall > normal fetch.
REQ-018 Normal fetch: PC <= PC+1 mod 256 (0xFF wraps to 0x00), if_instruction <= imem_data, if_pc_plus1 <= PC+1 mod 256, if_valid <= 1.
REQ-019 branch_taken: PC <= branch_target, IF/ID <= NOP, if_pc_plus1 <= 0x00, if_valid <= 0; applies even if stall or flush high.
REQ-020 flush (no branch): PC <= PC+1, IF/ID <= NOP, if_valid <= 0; stall+flush together: PC held, IF/ID <= NOP.
REQ-021 stall only: PC, if_instruction, if_pc_plus1, if_valid all hold.
REQ-022 halt in RUN: next state HALT, PC held, IF/ID <= NOP, if_valid <= 0.
REQ-023 HALT SHALL be exited only by reset; in HALT all inputs except reset_n are ignored, halted=1.
REQ-024 fetch latency SHALL be one cycle: word at imem_address in cycle N appears on if_instruction in cycle N+1.

Reset
REQ-025 While reset_n=0 at a rising edge: PC=0x00, state=START, if_instruction=16'h0000, if_pc_plus1=0x00, if_valid=0, halted=0, fetch_count=0.
REQ-026 Reset asserted mid-operation (any state, including HALT or stall) SHALL override all other inputs that cycle.

Configuration
REQ-027 Macro IF_FETCH_COUNTER_EN defined: fetch_count increments by 1 on each cycle if_valid is loaded with 1, saturating at 16'hFFFF.
REQ-028 Macro IF_FETCH_COUNTER_EN undefined: fetch_count SHALL be constant 16'h0000 and no counter register is synthesized.

Verification
REQ-029 Reset release, memory 0x00=16'h0000, 0x01=16'h4806 -> cycle 1 START, if_valid=0; cycle 2 if_instruction=16'h0000, if_pc_plus1=0x01; cycle 3 if_instruction=16'h4806, if_pc_plus1=0x02.
REQ-030 PC=0x05, stall=1 for 3 cycles -> imem_address stays 0x05, IF/ID outputs unchanged; release -> fetch resumes at 0x05.
REQ-031 PC=0x0C, branch_taken=1, branch_target=0x02, stall=1 -> next cycle imem_address=0x02, if_instruction=16'h0000, if_valid=0.
REQ-032 Drive PC to 0xFF via branch, normal fetch -> imem_address=0x00, if_pc_plus1=0x00.
REQ-033 halt=1 at PC=0x11 -> halted=1, imem_address frozen 0x11, branch/stall ignored; reset_n=0 one cycle -> PC=0x00, START.
REQ-034 With IF_FETCH_COUNTER_EN: 10 normal fetches, 1 flush -> fetch_count=10; without macro -> fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC + IF/ID stage with START/RUN/HALT control; IF_FETCH_COUNTER_EN adds a saturating fetch counter
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  imem_address,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instruction,
  output logic [7:0]  if_pc_plus1,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);
  typedef enum logic [1:0] {START, RUN, HALT} state_t;
  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [7:0]  r_pcp1;
  logic        r_valid;
  logic        r_halted;
  logic        w_fetch;
  logic [7:0]  w_pc_inc;
  assign w_pc_inc       = r_pc + 8'd1;
  assign w_fetch        = (r_state == RUN) && !halt && !branch_taken && !flush && !stall;
  assign imem_address   = r_pc;
  assign if_instruction = r_instr;
  assign if_pc_plus1    = r_pcp1;
  assign if_valid       = r_valid;
  assign halted         = r_halted;
  // control FSM and IF/ID register; priority halt > branch > flush > stall > fetch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= START;
      r_pc     <= '0;
      r_instr  <= '0;
      r_pcp1   <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          r_state <= RUN;
          r_instr <= '0;
          r_pcp1  <= '0;
          r_valid <= 1'b0;
        end
        RUN: begin
          if (halt) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
            r_instr  <= '0;
            r_pcp1   <= '0;
            r_valid  <= 1'b0;
          end else if (branch_taken) begin
            r_pc    <= branch_target;
            r_instr <= '0;
            r_pcp1  <= '0;
            r_valid <= 1'b0;
          end else if (flush) begin
            r_pc    <= stall ? r_pc : w_pc_inc;
            r_instr <= '0;
            r_pcp1  <= '0;
            r_valid <= 1'b0;
          end else if (w_fetch) begin
            r_pc    <= w_pc_inc;
            r_instr <= imem_data;
            r_pcp1  <= w_pc_inc;
            r_valid <= 1'b1;
          end
        end
        HALT: r_halted <= 1'b1;
        default: r_state <= START;
      endcase
    end
  end
`ifdef IF_FETCH_COUNTER_EN
  logic [15:0] r_fetch_count;
  // count cycles that load a real fetch, sticking at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) r_fetch_count <= '0;
    else if (w_fetch && r_fetch_count != 16'hFFFF) r_fetch_count <= r_fetch_count + 16'd1;
  end
  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 16'h0000;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with directed and random stimulus against a behavioural fetch model
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0, stall = 1'b0, flush = 1'b0, halt = 1'b0, branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  imem_address;
  logic [15:0] imem_data, if_instruction, fetch_count;
  logic [7:0]  if_pc_plus1;
  logic        if_valid, halted;
  logic [15:0] mem [256];
  int tests = 0, fails = 0;
  bit done = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [7:0]  pcp1;
    logic        valid;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  // model state: phase 0=start,1=run,2=halt
  int          m_phase;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_pcp1;
  logic        m_valid, m_halted;
  int          m_fetches;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_address];

  instruction_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_address(imem_address), .imem_data(imem_data),
    .if_instruction(if_instruction), .if_pc_plus1(if_pc_plus1), .if_valid(if_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic nop_ifid();
    m_instr = 16'h0000; m_pcp1 = 8'h00; m_valid = 1'b0;
  endtask

  // drive one cycle of inputs and predict the outputs after the next rising edge
  task automatic step(input logic rn, input logic st, input logic fl, input logic ht,
                      input logic br, input logic [7:0] bt);
    exp_t e;
    @(negedge clk);
    reset_n = rn; stall = st; flush = fl; halt = ht; branch_taken = br; branch_target = bt;
    if (!rn) begin
      m_phase = 0; m_pc = 8'h00; nop_ifid(); m_halted = 1'b0; m_fetches = 0;
    end else if (m_phase == 0) begin
      nop_ifid(); m_phase = 1;
    end else if (m_phase == 1) begin
      if (ht) begin m_phase = 2; m_halted = 1'b1; nop_ifid(); end
      else if (br) begin m_pc = bt; nop_ifid(); end
      else if (fl) begin if (!st) m_pc = 8'((int'(m_pc) + 1) % 256); nop_ifid(); end
      else if (!st) begin
        m_instr = mem[m_pc];
        m_pc = 8'((int'(m_pc) + 1) % 256);
        m_pcp1 = m_pc;
        m_valid = 1'b1;
        m_fetches++;
      end
    end
    e.addr = m_pc; e.instr = m_instr; e.pcp1 = m_pcp1; e.valid = m_valid; e.hlt = m_halted;
`ifdef IF_FETCH_COUNTER_EN
    e.cnt = (m_fetches > 65535) ? 16'hFFFF : 16'(m_fetches);
`else
    e.cnt = 16'h0000;
`endif
    q.push_back(e);
  endtask

  task automatic run(input logic st, input logic fl, input logic ht, input logic br, input logic [7:0] bt);
    step(1'b1, st, fl, ht, br, bt);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: after each edge, compare DUT outputs with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_address", 16'(imem_address), 16'(e.addr));
        chk("if_instruction", if_instruction, e.instr);
        chk("if_pc_plus1", 16'(if_pc_plus1), 16'(e.pcp1));
        chk("if_valid", 16'(if_valid), 16'(e.valid));
        chk("halted", 16'(halted), 16'(e.hlt));
        chk("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0000; mem[1] = 16'h4806;
    step(1'b0, 0, 0, 0, 0, 8'h00);
    step(1'b0, 0, 0, 0, 0, 8'h00);
    run(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) run(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) run(1, 0, 0, 0, 8'h00);
    run(0, 0, 0, 0, 8'h00);
    run(0, 0, 0, 1, 8'h0C);
    run(1, 0, 0, 1, 8'h02);
    run(1, 1, 0, 0, 8'h00);
    run(0, 1, 0, 0, 8'h00);
    run(0, 0, 0, 1, 8'hFF);
    run(0, 0, 0, 0, 8'h00);
    run(0, 0, 0, 0, 8'h00);
    run(0, 0, 0, 1, 8'h11);
    run(0, 0, 1, 0, 8'h00);
    run(1, 0, 0, 1, 8'h40);
    run(0, 1, 0, 1, 8'h50);
    run(0, 0, 1, 0, 8'h00);
    step(1'b0, 1, 0, 1, 1, 8'h22);
    run(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) run(0, 0, 0, 0, 8'h00);
    run(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 79) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d predictions never compared, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
